// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
//   Controller for a multi-cycle RV32I-subset datapath (lw, sw, R-type,
//   I-type ALU, beq, jal). A state register sequences fetch / decode /
//   execute / memory / writeback over one shared ALU and one unified memory.
//   Memory accesses in FETCH, MEMREAD and MEMWRITE stretch until mem_ready.
//   Any other opcode is reported on `illegal`.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active-low
//   op         in   [6:0] opcode from the instruction register
//   func3      in   [2:0] funct3 from the instruction register
//   func7      in   [6:0] funct7 (only bit 5 is used)
//   zero       in   ALU zero flag (beq outcome)
//   mem_ready  in   memory completes the access this cycle
//   PCWrite    out  load PC
//   AdrSrc     out  memory address select (0 PC, 1 Result)
//   MemWrite   out  memory write strobe
//   IRWrite    out  load IR / OldPC
//   ResultSrc  out  [1:0] 00 ALUOut, 01 Data, 10 ALUResult
//   ALUSrcA    out  [1:0] 00 PC, 01 OldPC, 10 rs1
//   ALUSrcB    out  [1:0] 00 rs2, 01 Imm, 10 constant 4
//   ImmSrc     out  [1:0] 00 I, 01 S, 10 B, 11 J
//   RegWrite   out  register file write
//   ALUControl out  [ALUCTRL_W-1:0] 000 add, 001 sub, 010 and, 011 or, 101 slt
//   illegal    out  illegal opcode / funct3 flag
//   state_o    out  [3:0] current state code (debug)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module multicycle_control_unit #(
    parameter int ALUCTRL_W    = 3,
    parameter int MEM_WAIT_EN  = 1,
    parameter int ILLEGAL_TRAP = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           op,
    input  logic [2:0]           func3,
    input  logic [6:0]           func7,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic                 RegWrite,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 illegal,
    output logic [3:0]           state_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // ALU decode for the execute states: returns {bad_func3, alu_op}.
    // Unsupported funct3 values still add so the state flow is unaffected.
    function automatic logic [3:0] alu_decode(input logic [2:0] f3,
                                              input logic       is_r,
                                              input logic       f7b5);
        logic [3:0] r;
        r = 4'b0000;
        case (f3)
            3'b000:  r[2:0] = (is_r && f7b5) ? 3'b001 : 3'b000;
            3'b010:  r[2:0] = 3'b101;
            3'b110:  r[2:0] = 3'b011;
            3'b111:  r[2:0] = 3'b010;
            default: r      = 4'b1000;
        endcase
        return r;
    endfunction

    function automatic logic op_supported(input logic [6:0] o);
        logic ok;
        case (o)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL: ok = 1'b1;
            default:                                                 ok = 1'b0;
        endcase
        return ok;
    endfunction

    state_t     state_r;
    logic       mem_ok_s;
    logic       unused_s;

    logic       adr_src_s, mem_write_s, ir_write_s, reg_write_s;
    logic       pc_update_s, branch_s, illegal_s;
    logic [1:0] result_src_s, alu_src_a_s, alu_src_b_s, imm_src_s;
    logic [2:0] alu_op_s;

    // With waiting disabled every memory access completes in one cycle.
    assign mem_ok_s = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;
    assign unused_s = ^{func7[6], func7[4:0]};
    assign state_o  = state_r;

    // Instruction sequencing state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_FETCH;
        end else begin
            case (state_r)
                S_FETCH:    state_r <= mem_ok_s ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (op)
                        OP_LOAD, OP_STORE: state_r <= S_MEMADR;
                        OP_RTYPE:          state_r <= S_EXECR;
                        OP_ITYPE:          state_r <= S_EXECI;
                        OP_BRANCH:         state_r <= S_BEQ;
                        OP_JAL:            state_r <= S_JAL;
                        default:           state_r <= (ILLEGAL_TRAP != 0) ? S_ILLEGAL : S_FETCH;
                    endcase
                end
                S_MEMADR:   state_r <= (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  state_r <= mem_ok_s ? S_MEMWB : S_MEMREAD;
                S_MEMWB:    state_r <= S_FETCH;
                S_MEMWRITE: state_r <= mem_ok_s ? S_FETCH : S_MEMWRITE;
                S_EXECR:    state_r <= S_ALUWB;
                S_EXECI:    state_r <= S_ALUWB;
                S_ALUWB:    state_r <= S_FETCH;
                S_BEQ:      state_r <= S_FETCH;
                S_JAL:      state_r <= S_ALUWB;   // write rd = old PC + 4
                S_ILLEGAL:  state_r <= S_ILLEGAL;
                default:    state_r <= S_FETCH;
            endcase
        end
    end

    // Per-state control decode; fetch strobes and branch are qualified by inputs.
    always_comb begin
        adr_src_s    = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        pc_update_s  = 1'b0;
        branch_s     = 1'b0;
        illegal_s    = 1'b0;
        result_src_s = 2'b00;
        alu_src_a_s  = 2'b00;
        alu_src_b_s  = 2'b00;
        imm_src_s    = 2'b00;
        alu_op_s     = 3'b000;
        case (state_r)
            S_FETCH: begin
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
                ir_write_s   = mem_ok_s;
                pc_update_s  = mem_ok_s;
            end
            S_DECODE: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b01;
                imm_src_s   = 2'b10;
                illegal_s   = (ILLEGAL_TRAP == 0) && !op_supported(op);
            end
            S_MEMADR: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                imm_src_s   = (op == OP_STORE) ? 2'b01 : 2'b00;
            end
            S_MEMREAD:  adr_src_s = 1'b1;
            S_MEMWRITE: begin
                adr_src_s   = 1'b1;
                mem_write_s = 1'b1;
            end
            S_MEMWB: begin
                result_src_s = 2'b01;
                reg_write_s  = 1'b1;
            end
            S_EXECR: begin
                alu_src_a_s           = 2'b10;
                {illegal_s, alu_op_s} = alu_decode(func3, 1'b1, func7[5]);
            end
            S_EXECI: begin
                alu_src_a_s           = 2'b10;
                alu_src_b_s           = 2'b01;
                {illegal_s, alu_op_s} = alu_decode(func3, 1'b0, func7[5]);
            end
            S_ALUWB:    reg_write_s = 1'b1;
            S_BEQ: begin
                alu_src_a_s = 2'b10;
                alu_op_s    = 3'b001;
                branch_s    = 1'b1;
            end
            S_JAL: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b10;
                pc_update_s = 1'b1;
            end
            S_ILLEGAL:  illegal_s = 1'b1;
            default:    illegal_s = 1'b0;
        endcase
    end

    // Output stage: while reset is held every strobe and mux select is 0.
    always_comb begin
        ALUControl = '0;
        if (rst) begin
            PCWrite         = pc_update_s | (branch_s & zero);
            AdrSrc          = adr_src_s;
            MemWrite        = mem_write_s;
            IRWrite         = ir_write_s;
            ResultSrc       = result_src_s;
            ALUSrcA         = alu_src_a_s;
            ALUSrcB         = alu_src_b_s;
            ImmSrc          = imm_src_s;
            RegWrite        = reg_write_s;
            ALUControl[2:0] = alu_op_s;
            illegal         = illegal_s;
        end else begin
            PCWrite   = 1'b0;
            AdrSrc    = 1'b0;
            MemWrite  = 1'b0;
            IRWrite   = 1'b0;
            ResultSrc = 2'b00;
            ALUSrcA   = 2'b00;
            ALUSrcB   = 2'b00;
            ImmSrc    = 2'b00;
            RegWrite  = 1'b0;
            illegal   = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_unit
//   Drives whole instructions (directed, then random) into the controller and
//   compares every cycle's full control vector against a reference built from
//   each instruction class's step list and a per-step output table.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state_o;

    int n_vec = 0;
    int n_err = 0;
    int irw_cnt;
    int rw_cnt;

    typedef struct packed {
        logic       pcw, adr, memw, irw;
        logic [1:0] rsrc, srca, srcb, imm;
        logic       regw;
        logic [2:0] alu;
        logic       ill;
        logic [3:0] st;
    } ctl_t;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BEQ = 4, K_JAL = 5, K_ILL = 6;

    multicycle_control_unit dut (
        .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7),
        .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .RegWrite(RegWrite), .ALUControl(ALUControl), .illegal(illegal),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs_vec();
        ctl_t o;
        o = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
             ImmSrc, RegWrite, ALUControl, illegal, state_o};
        return {11'd0, o};
    endfunction

    // ALU operation for an execute step: {bad_func3, op}
    function automatic logic [3:0] alu_ref(input logic [2:0] f3, input bit is_r, input logic f7b5);
        if (f3 == 3'd0)      return (is_r && f7b5) ? 4'd1 : 4'd0;
        else if (f3 == 3'd2) return 4'd5;
        else if (f3 == 3'd6) return 4'd3;
        else if (f3 == 3'd7) return 4'd2;
        else                 return 4'b1000;
    endfunction

    // Expected control vector for one step (state code) given this cycle's inputs.
    function automatic logic [31:0] ref_vec(input int step, input logic mr, input logic z,
                                            input logic [6:0] o, input logic [2:0] f3,
                                            input logic f7b5);
        ctl_t e;
        e    = '0;
        e.st = 4'(step);
        case (step)
            0:  begin e.srcb = 2'd2; e.rsrc = 2'd2; e.irw = mr; e.pcw = mr; end
            1:  begin e.srca = 2'd1; e.srcb = 2'd1; e.imm = 2'd2; end
            2:  begin e.srca = 2'd2; e.srcb = 2'd1; e.imm = (o == 7'b0100011) ? 2'd1 : 2'd0; end
            3:  e.adr = 1'b1;
            4:  begin e.rsrc = 2'd1; e.regw = 1'b1; end
            5:  begin e.adr = 1'b1; e.memw = 1'b1; end
            6:  begin e.srca = 2'd2; {e.ill, e.alu} = alu_ref(f3, 1'b1, f7b5); end
            7:  begin e.srca = 2'd2; e.srcb = 2'd1; {e.ill, e.alu} = alu_ref(f3, 1'b0, f7b5); end
            8:  e.regw = 1'b1;
            9:  begin e.srca = 2'd2; e.alu = 3'd1; e.pcw = z; end
            10: begin e.srca = 2'd1; e.srcb = 2'd2; e.pcw = 1'b1; end
            11: e.ill = 1'b1;
            default: e = '0;
        endcase
        return {11'd0, e};
    endfunction

    // One clock of a given step: drive, sample on the falling edge, advance.
    task automatic cycle(input int step, input logic mr, input logic z);
        mem_ready = mr;
        zero      = z;
        @(negedge clk);
        check_eq($sformatf("step%0d", step), obs_vec(), ref_vec(step, mr, z, op, func3, func7[5]));
        irw_cnt += int'(IRWrite);
        rw_cnt  += int'(RegWrite);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_hold();
        for (int i = 0; i < 2; i++) begin
            mem_ready = 1'b1;
            zero      = 1'($urandom);
            @(negedge clk);
            check_eq("rst_hold", obs_vec(), 32'd0);
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check_eq("rst_async", obs_vec(), 32'd0);
        reset_hold();
    endtask

    // fw / mw: cycles with mem_ready low before completion in fetch / memory steps.
    // zsel: 0 or 1 forces the zero flag, 2 randomizes it.
    task automatic run_instr(input int kind, input logic [2:0] f3, input logic f7b5,
                             input int fw, input int mw, input int zsel, input logic [6:0] bad_op);
        int   seq[$];
        int   waits;
        logic z;
        case (kind)
            K_LW:    begin op = 7'b0000011; seq = '{0, 1, 2, 3, 4}; end
            K_SW:    begin op = 7'b0100011; seq = '{0, 1, 2, 5};    end
            K_R:     begin op = 7'b0110011; seq = '{0, 1, 6, 8};    end
            K_I:     begin op = 7'b0010011; seq = '{0, 1, 7, 8};    end
            K_BEQ:   begin op = 7'b1100011; seq = '{0, 1, 9};       end
            K_JAL:   begin op = 7'b1101111; seq = '{0, 1, 10, 8};   end
            default: begin op = bad_op;     seq = '{0, 1, 11, 11, 11, 11}; end
        endcase
        func3    = f3;
        func7    = 7'($urandom);
        func7[5] = f7b5;
        irw_cnt  = 0;
        rw_cnt   = 0;
        foreach (seq[i]) begin
            z = (zsel == 2) ? 1'($urandom) : 1'(zsel);
            if (seq[i] == 0 || seq[i] == 3 || seq[i] == 5) begin
                waits = (seq[i] == 0) ? fw : mw;
                for (int w = 0; w <= waits; w++) cycle(seq[i], (w == waits), z);
            end else begin
                cycle(seq[i], 1'($urandom), z);
            end
        end
        check_eq("ir_pulses", 32'(irw_cnt), 32'd1);
        check_eq("rw_pulses", 32'(rw_cnt),
                 (kind == K_LW || kind == K_R || kind == K_I || kind == K_JAL) ? 32'd1 : 32'd0);
        if (kind == K_ILL) do_reset();
    endtask

    function automatic logic [2:0] pick_f3();
        logic [2:0] tbl [4] = '{3'd0, 3'd2, 3'd6, 3'd7};
        if ($urandom_range(0, 4) == 0) return 3'($urandom);
        return tbl[$urandom_range(0, 3)];
    endfunction

    initial begin
        logic [6:0] ill_ops [4] = '{7'b1111111, 7'b0000000, 7'b0110111, 7'b1100111};
        rst = 1'b0; mem_ready = 1'b1; zero = 1'b0;
        op = 7'b0110011; func3 = 3'd0; func7 = 7'd0;
        @(posedge clk);
        #1;
        reset_hold();

        run_instr(K_R, 3'd0, 1'b1, 0, 0, 2, 7'd0);          // sub
        run_instr(K_LW, 3'd2, 1'b0, 3, 2, 2, 7'd0);         // 10-cycle lw
        run_instr(K_SW, 3'd2, 1'b0, 0, 2, 2, 7'd0);         // MemWrite 3 cycles
        run_instr(K_BEQ, 3'd0, 1'b0, 0, 0, 1, 7'd0);        // taken
        run_instr(K_BEQ, 3'd0, 1'b0, 0, 0, 0, 7'd0);        // not taken
        run_instr(K_JAL, 3'd0, 1'b0, 0, 0, 2, 7'd0);
        run_instr(K_I, 3'd1, 1'b0, 1, 0, 2, 7'd0);          // bad funct3 flag
        run_instr(K_ILL, 3'd0, 1'b0, 0, 0, 2, 7'b1111111);  // trap, then reset

        // Asynchronous reset in the middle of a store's write phase.
        op = 7'b0100011; func3 = 3'd2; func7 = 7'd0;
        cycle(0, 1'b1, 1'b0);
        cycle(1, 1'b1, 1'b0);
        cycle(2, 1'b1, 1'b0);
        mem_ready = 1'b0;
        #2;
        check_eq("mw_pre", obs_vec(), ref_vec(5, 1'b0, 1'b0, op, func3, 1'b0));
        rst = 1'b0;
        #1;
        check_eq("mw_async", obs_vec(), 32'd0);
        @(posedge clk);
        #1;
        reset_hold();

        for (int n = 0; n < 200; n++) begin
            run_instr($urandom_range(0, 6), pick_f3(), 1'($urandom),
                      $urandom_range(0, 3), $urandom_range(0, 3), 2,
                      ill_ops[$urandom_range(0, 3)]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
